// File: rtl/periph_pkg.sv
// Shared constants for the memory-mapped peripheral block: register word
// offsets within the 8-word window, TCON bit positions and the default base.
package periph_pkg;

  localparam logic [31:0] BASE_ADDR_DEFAULT = 32'h4000_0000;

  // Word offsets (addr[4:2]) inside the register window.
  localparam logic [2:0] OFF_TH      = 3'd0;
  localparam logic [2:0] OFF_TL      = 3'd1;
  localparam logic [2:0] OFF_TCON    = 3'd2;
  localparam logic [2:0] OFF_LED     = 3'd3;
  localparam logic [2:0] OFF_SWITCH  = 3'd4;
  localparam logic [2:0] OFF_DIGI    = 3'd5;
  localparam logic [2:0] OFF_SYSTICK = 3'd6;

  localparam int TCON_EN    = 0;
  localparam int TCON_IRQEN = 1;
  localparam int TCON_IRQST = 2;

endpackage

// File: rtl/timer_unit.sv
// Up-counting reload timer (TH/TL/TCON) with level interrupt request.
// Bus writes take priority over counting; a coincident overflow still sets status.
module timer_unit
  import periph_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_we_th,
  input  logic        i_we_tl,
  input  logic        i_we_tcon,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_th,
  output logic [31:0] o_tl,
  output logic [2:0]  o_tcon,
  output logic        o_irq
);

  logic [31:0] r_th;
  logic [31:0] r_tl;
  logic [2:0]  r_tcon;
  logic        w_ovf;
  logic        w_irq_set;

  assign w_ovf     = r_tcon[TCON_EN] && (r_tl == 32'hFFFF_FFFF);
  assign w_irq_set = w_ovf && r_tcon[TCON_IRQEN];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_th   <= 32'd0;
      r_tl   <= 32'd0;
      r_tcon <= 3'd0;
    end else begin
      if (i_we_th)
        r_th <= i_wdata;

      if (i_we_tl)
        r_tl <= i_wdata;
      else if (r_tcon[TCON_EN])
        r_tl <= w_ovf ? r_th : r_tl + 32'd1;

      // Status set wins over a simultaneous software clear so no interrupt is lost.
      if (i_we_tcon)
        r_tcon <= {i_wdata[TCON_IRQST] | w_irq_set, i_wdata[TCON_IRQEN], i_wdata[TCON_EN]};
      else if (w_irq_set)
        r_tcon[TCON_IRQST] <= 1'b1;
    end
  end

  assign o_th   = r_th;
  assign o_tl   = r_tl;
  assign o_tcon = r_tcon;
  assign o_irq  = r_tcon[TCON_IRQEN] & r_tcon[TCON_IRQST];

endmodule

// File: rtl/peripheral_bus.sv
// Memory-mapped I/O responder on the CPU data bus: address decode, zero-latency
// read mux, LED/7-seg/systick registers, switch synchroniser and the timer.
module peripheral_bus
  import periph_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEFAULT,
  parameter int          LED_W     = 8,
  parameter int          SW_W      = 8,
  parameter int          DIGI_W    = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd,
  input  logic              wr,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  input  logic [SW_W-1:0]   switch,
  output logic [LED_W-1:0]  led,
  output logic [DIGI_W-1:0] digi,
  output logic              irqout
);

  logic              w_hit;
  logic [2:0]        w_off;
  logic              w_we;
  logic              w_unused;
  logic [31:0]       w_th;
  logic [31:0]       w_tl;
  logic [2:0]        w_tcon;
  logic [LED_W-1:0]  r_led;
  logic [DIGI_W-1:0] r_digi;
  logic [31:0]       r_systick;
  logic [SW_W-1:0]   r_sw_meta;
  logic [SW_W-1:0]   r_sw_sync;

  assign w_hit    = (addr[31:5] == BASE_ADDR[31:5]);
  assign w_off    = addr[4:2];
  assign w_we     = wr && w_hit;
  // Byte lane bits are don't-care: all registers are word-wide.
  assign w_unused = ^addr[1:0];

  timer_unit u_timer (
    .i_clk     (clk),
    .i_rst_n   (reset),
    .i_we_th   (w_we && (w_off == OFF_TH)),
    .i_we_tl   (w_we && (w_off == OFF_TL)),
    .i_we_tcon (w_we && (w_off == OFF_TCON)),
    .i_wdata   (wdata),
    .o_th      (w_th),
    .o_tl      (w_tl),
    .o_tcon    (w_tcon),
    .o_irq     (irqout)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_led     <= '0;
      r_digi    <= '0;
      r_systick <= 32'd0;
      r_sw_meta <= '0;
      r_sw_sync <= '0;
    end else begin
      if (w_we && (w_off == OFF_LED))
        r_led <= wdata[LED_W-1:0];
      if (w_we && (w_off == OFF_DIGI))
        r_digi <= wdata[DIGI_W-1:0];
      r_systick <= r_systick + 32'd1;
      r_sw_meta <= switch;
      r_sw_sync <= r_sw_meta;
    end
  end

  always_comb begin
    rdata = 32'd0;
    if (rd && w_hit) begin
      case (w_off)
        OFF_TH:      rdata = w_th;
        OFF_TL:      rdata = w_tl;
        OFF_TCON:    rdata = 32'(w_tcon);
        OFF_LED:     rdata = 32'(r_led);
        OFF_SWITCH:  rdata = 32'(r_sw_sync);
        OFF_DIGI:    rdata = 32'(r_digi);
        OFF_SYSTICK: rdata = r_systick;
        default:     rdata = 32'd0;
      endcase
    end
  end

  assign led  = r_led;
  assign digi = r_digi;

endmodule
